// File: rtl/kamacore_stage_mem_pkg.sv
// Shared types and constants for the kamacore memory-access stage.
package kamacore_stage_mem_pkg;
    localparam int CPU_WIDTH = 32;
    localparam int CTRL_W    = 8;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_fsm_t;

    // funct3[1:0] = 11 has no RV32 meaning; it is treated as a word access.
    function automatic mem_size_t funct3_to_size(input logic [1:0] f);
        case (f)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction
endpackage

// File: rtl/kamacore_stage_mem_if.sv
// Stage-buffer and forwarding interfaces used around the kamacore memory stage.
interface kamacore_ex_mem_if;
    import kamacore_stage_mem_pkg::*;
    logic [31:0]          instruction;
    logic [CPU_WIDTH-1:0] alu_result;
    logic [CPU_WIDTH-1:0] rs2_data;
    logic [CTRL_W-1:0]    control_signals;
    modport sink (input instruction, alu_result, rs2_data, control_signals);
endinterface

interface kamacore_mem_wb_if;
    import kamacore_stage_mem_pkg::*;
    logic [31:0]          instruction;
    logic [CPU_WIDTH-1:0] alu_result;
    logic [CPU_WIDTH-1:0] mem_data;
    logic [CTRL_W-1:0]    control_signals;
    modport source (output instruction, alu_result, mem_data, control_signals);
endinterface

interface kamacore_fwd_if;
    import kamacore_stage_mem_pkg::*;
    logic [4:0]           a;
    logic [CPU_WIDTH-1:0] data_original;
    modport source (output a, data_original);
endinterface

// File: rtl/kamacore_stage_mem_lsu_align.sv
// kamacore_lsu_align: combinational byte-lane steering for stores and lane select/extension for loads.
module kamacore_lsu_align
    import kamacore_stage_mem_pkg::*;
(
    input  mem_size_t   i_st_size,
    input  logic [1:0]  i_st_addr,
    input  logic [31:0] i_wdata,
    input  mem_size_t   i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [1:0]  i_ld_addr,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_st_size)
            BYTE: begin
                o_be    = 4'b0001 << i_st_addr;
                o_wdata = {4{i_wdata[7:0]}};
            end
            HALF: begin
                o_be    = i_st_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Sign bit is masked off for LBU/LHU so one concatenation covers both extensions.
    always_comb begin
        w_byte    = i_rdata[{i_ld_addr, 3'b000} +: 8];
        w_half    = i_ld_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ld_data = i_rdata;
        case (i_ld_size)
            BYTE:    o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
            HALF:    o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/kamacore_stage_mem.sv
// kamacore_stage_mem: memory-access stage driving a single-outstanding req/ack data bus.
// Define KAMACORE_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating them.
module kamacore_stage_mem
    import kamacore_stage_mem_pkg::*;
#(
    parameter int DMEM_AW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    kamacore_ex_mem_if.sink      pipeline_ex_mem,
    kamacore_mem_wb_if.source    pipeline_mem_wb,
    kamacore_fwd_if.source       forwarding_mem,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DMEM_AW-1:0]   dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [31:0]          dmem_rdata
`ifdef KAMACORE_MISALIGN_TRAP_EN
    ,
    output logic                 trap_misaligned,
    output logic [DMEM_AW-1:0]   trap_addr
`endif
);
    mem_fsm_t     r_state;
    mem_size_t    r_size;
    logic         r_unsigned;
    logic [1:0]   r_addr_lo;
    logic         r_is_load;

    logic [6:0]   w_opcode;
    logic         w_is_load;
    logic         w_is_store;
    logic         w_is_mem;
    logic         w_misaligned;
    logic         w_issue;
    mem_size_t    w_size;
    logic [DMEM_AW-1:0] w_addr;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [31:0]  w_ld_data;

    assign w_opcode   = pipeline_ex_mem.instruction[6:0];
    assign w_is_load  = (w_opcode == OPC_LOAD);
    assign w_is_store = (w_opcode == OPC_STORE);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_size     = funct3_to_size(pipeline_ex_mem.instruction[13:12]);
    assign w_addr     = DMEM_AW'(pipeline_ex_mem.alu_result);

`ifdef KAMACORE_MISALIGN_TRAP_EN
    assign w_misaligned = w_is_mem && (((w_size == HALF) && w_addr[0]) ||
                                       ((w_size == WORD) && (w_addr[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif
    assign w_issue = w_is_mem & ~w_misaligned;

    assign stall = (r_state == IDLE) ? w_issue : ~dmem_ack;

    // Loads never forward: their data is not known until writeback.
    assign forwarding_mem.a             = w_is_load ? 5'd0 : pipeline_ex_mem.instruction[11:7];
    assign forwarding_mem.data_original = pipeline_ex_mem.alu_result;

    kamacore_lsu_align u_align (
        .i_st_size     (w_size),
        .i_st_addr     (w_addr[1:0]),
        .i_wdata       (pipeline_ex_mem.rs2_data),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_ld_addr     (r_addr_lo),
        .i_rdata       (dmem_rdata),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state                         <= IDLE;
            r_size                          <= BYTE;
            r_unsigned                      <= 1'b0;
            r_addr_lo                       <= 2'b00;
            r_is_load                       <= 1'b0;
            dmem_req                        <= 1'b0;
            dmem_we                         <= 1'b0;
            dmem_addr                       <= '0;
            dmem_be                         <= '0;
            dmem_wdata                      <= '0;
            pipeline_mem_wb.instruction     <= '0;
            pipeline_mem_wb.alu_result      <= '0;
            pipeline_mem_wb.mem_data        <= '0;
            pipeline_mem_wb.control_signals <= '0;
`ifdef KAMACORE_MISALIGN_TRAP_EN
            trap_misaligned                 <= 1'b0;
            trap_addr                       <= '0;
`endif
        end else begin
            // Bubble unless a non-memory op or a completing access overrides it below.
            pipeline_mem_wb.instruction     <= '0;
            pipeline_mem_wb.alu_result      <= '0;
            pipeline_mem_wb.mem_data        <= '0;
            pipeline_mem_wb.control_signals <= '0;
`ifdef KAMACORE_MISALIGN_TRAP_EN
            trap_misaligned <= (r_state == IDLE) && w_misaligned;
            if ((r_state == IDLE) && w_misaligned) trap_addr <= w_addr;
`endif
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= w_is_store;
                        dmem_addr  <= {w_addr[DMEM_AW-1:2], 2'b00};
                        dmem_be    <= w_be;
                        dmem_wdata <= w_wdata;
                        r_size     <= w_size;
                        r_unsigned <= pipeline_ex_mem.instruction[14];
                        r_addr_lo  <= w_addr[1:0];
                        r_is_load  <= w_is_load;
                        r_state    <= BUSY;
                    end else if (!w_misaligned) begin
                        pipeline_mem_wb.instruction     <= pipeline_ex_mem.instruction;
                        pipeline_mem_wb.alu_result      <= pipeline_ex_mem.alu_result;
                        pipeline_mem_wb.control_signals <= pipeline_ex_mem.control_signals;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req                        <= 1'b0;
                        r_state                         <= IDLE;
                        pipeline_mem_wb.instruction     <= pipeline_ex_mem.instruction;
                        pipeline_mem_wb.alu_result      <= pipeline_ex_mem.alu_result;
                        pipeline_mem_wb.control_signals <= pipeline_ex_mem.control_signals;
                        pipeline_mem_wb.mem_data        <= r_is_load ? w_ld_data : '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kamacore_stage_mem.sv
// Scoreboard bench for kamacore_stage_mem: stimulus queues expected bus requests and writebacks, a monitor checks them.
module tb_kamacore_stage_mem;
    import kamacore_stage_mem_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        chk_mem;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
`ifdef KAMACORE_MISALIGN_TRAP_EN
    logic        trap_misaligned;
    logic [31:0] trap_addr;
`endif

    kamacore_ex_mem_if ex_if ();
    kamacore_mem_wb_if wb_if ();
    kamacore_fwd_if    fwd_if ();

    kamacore_stage_mem #(.DMEM_AW(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pipeline_ex_mem (ex_if),
        .pipeline_mem_wb (wb_if),
        .forwarding_mem  (fwd_if),
        .stall           (stall),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata)
`ifdef KAMACORE_MISALIGN_TRAP_EN
        ,
        .trap_misaligned (trap_misaligned),
        .trap_addr       (trap_addr)
`endif
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    req_t req_q[$];
    wb_t  wb_q[$];
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic req_t mk_req(input logic we, input logic [31:0] addr,
                                     input logic [3:0] be, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
        return r;
    endfunction

    function automatic wb_t mk_wb(input logic [31:0] instr, input logic [31:0] alu,
                                   input logic [31:0] mem, input logic chk_mem);
        wb_t w;
        w.instr = instr; w.alu = alu; w.mem = mem; w.chk_mem = chk_mem;
        return w;
    endfunction

    // Monitor: a rising dmem_req is a new request; a non-zero wb instruction is a retired op.
    always @(negedge clk) begin : monitor
        req_t r;
        wb_t  w;
        if (dmem_req && !prev_req) begin
            if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
            else begin
                r = req_q.pop_front();
                chk("req_we",    32'(dmem_we), 32'(r.we));
                chk("req_addr",  dmem_addr,    r.addr);
                chk("req_be",    32'(dmem_be), 32'(r.be));
                chk("req_wdata", dmem_wdata,   r.wdata);
            end
        end
        prev_req <= dmem_req;
        if (wb_if.instruction != 32'd0) begin
            if (wb_q.size() == 0) chk("unexpected_wb", wb_if.instruction, 32'd0);
            else begin
                w = wb_q.pop_front();
                chk("wb_instr", wb_if.instruction, w.instr);
                chk("wb_alu",   wb_if.alu_result,  w.alu);
                if (w.chk_mem) chk("wb_mem_data", wb_if.mem_data, w.mem);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] rs2);
        ex_if.instruction     = instr;
        ex_if.alu_result      = alu;
        ex_if.rs2_data        = rs2;
        ex_if.control_signals = instr[7:0];
    endtask

    // Memory op presented at cycle N, acked in cycle N+k, then the ex_mem slot returns to NOP.
    task automatic mem_op(input string nm, input logic [31:0] instr, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int k,
                          input req_t er, input wb_t ew);
        req_q.push_back(er);
        wb_q.push_back(ew);
        drive(instr, alu, rs2);
        dmem_ack = 1'b0;
        @(negedge clk);
        chk({nm, "_stall_issue"}, 32'(stall), 32'd1);
        chk({nm, "_req_low_issue"}, 32'(dmem_req), 32'd0);
        if (instr[6:0] == OPC_LOAD) chk({nm, "_fwd_a_load"}, 32'(fwd_if.a), 32'd0);
        for (int i = 1; i <= k; i++) begin
            step();
            if (i == k) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            chk({nm, "_stall_busy"}, 32'(stall), 32'(i != k));
            chk({nm, "_req_busy"}, 32'(dmem_req), 32'd1);
            chk({nm, "_wb_bubble"}, wb_if.instruction, 32'd0);
        end
        step();
        dmem_ack = 1'b0;
        drive(32'd0, 32'd0, 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        drive(32'd0, 32'd0, 32'd0);
        repeat (3) step();
        @(negedge clk);
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_we",    32'(dmem_we),  32'd0);
        chk("rst_addr",  dmem_addr,     32'd0);
        chk("rst_be",    32'(dmem_be),  32'd0);
        chk("rst_wdata", dmem_wdata,    32'd0);
        chk("rst_wb",    wb_if.instruction | wb_if.alu_result | wb_if.mem_data, 32'd0);
        chk("rst_stall", 32'(stall),    32'd0);
        rst = 1'b1;
        step();

        // ADD x5: single cycle, forwarded, no stall.
        wb_q.push_back(mk_wb(32'h0000_02B3, 32'h1234, 32'd0, 1'b0));
        drive(32'h0000_02B3, 32'h1234, 32'd0);
        @(negedge clk);
        chk("add_stall", 32'(stall), 32'd0);
        chk("add_fwd_a", 32'(fwd_if.a), 32'd5);
        chk("add_fwd_data", fwd_if.data_original, 32'h1234);
        chk("add_req", 32'(dmem_req), 32'd0);
        step();
        drive(32'd0, 32'd0, 32'd0);
        step();

        mem_op("sw", 32'h0000_2023, 32'h100, 32'hDEAD_BEEF, 32'd0, 3,
               mk_req(1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF), mk_wb(32'h0000_2023, 32'h100, 32'd0, 1'b0));
        mem_op("lb", 32'h0000_0303, 32'h103, 32'd0, 32'h8012_3456, 1,
               mk_req(1'b0, 32'h100, 4'b1000, 32'd0), mk_wb(32'h0000_0303, 32'h103, 32'hFFFF_FF80, 1'b1));
        mem_op("lbu", 32'h0000_4303, 32'h103, 32'd0, 32'h8012_3456, 1,
               mk_req(1'b0, 32'h100, 4'b1000, 32'd0), mk_wb(32'h0000_4303, 32'h103, 32'h0000_0080, 1'b1));
        mem_op("sh", 32'h0000_1023, 32'h102, 32'h0000_ABCD, 32'd0, 2,
               mk_req(1'b1, 32'h100, 4'b1100, 32'hABCD_ABCD), mk_wb(32'h0000_1023, 32'h102, 32'd0, 1'b0));
        mem_op("lh", 32'h0000_1403, 32'h102, 32'd0, 32'h8001_5555, 1,
               mk_req(1'b0, 32'h100, 4'b1100, 32'd0), mk_wb(32'h0000_1403, 32'h102, 32'hFFFF_8001, 1'b1));
        mem_op("lhu", 32'h0000_5403, 32'h102, 32'd0, 32'h8001_5555, 1,
               mk_req(1'b0, 32'h100, 4'b1100, 32'd0), mk_wb(32'h0000_5403, 32'h102, 32'h0000_8001, 1'b1));
        mem_op("lw", 32'h0000_2383, 32'h104, 32'd0, 32'h1234_5678, 2,
               mk_req(1'b0, 32'h104, 4'b1111, 32'd0), mk_wb(32'h0000_2383, 32'h104, 32'h1234_5678, 1'b1));
        step();

`ifdef KAMACORE_MISALIGN_TRAP_EN
        drive(32'h0000_2383, 32'h101, 32'd0);
        @(negedge clk);
        chk("mis_stall", 32'(stall), 32'd0);
        chk("mis_req",   32'(dmem_req), 32'd0);
        step();
        drive(32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("mis_trap",      32'(trap_misaligned), 32'd1);
        chk("mis_trap_addr", trap_addr, 32'h101);
        chk("mis_wb_bubble", wb_if.instruction, 32'd0);
        chk("mis_req_after", 32'(dmem_req), 32'd0);
        step();
        @(negedge clk);
        chk("mis_trap_pulse", 32'(trap_misaligned), 32'd0);
        step();
`else
        mem_op("sw_unaligned", 32'h0000_2023, 32'h103, 32'h1122_3344, 32'd0, 1,
               mk_req(1'b1, 32'h100, 4'b1111, 32'h1122_3344), mk_wb(32'h0000_2023, 32'h103, 32'd0, 1'b0));
        step();
`endif

        // LW abandoned by reset in its second BUSY cycle; the late ack must be ignored.
        req_q.push_back(mk_req(1'b0, 32'h200, 4'b1111, 32'd0));
        drive(32'h0000_2383, 32'h200, 32'd0);
        @(negedge clk);
        chk("rstx_stall", 32'(stall), 32'd1);
        step();
        @(negedge clk);
        chk("rstx_req", 32'(dmem_req), 32'd1);
        step();
        rst = 1'b0;
        drive(32'd0, 32'd0, 32'd0);
        step();
        rst        = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rstx_req_clr",   32'(dmem_req), 32'd0);
        chk("rstx_we_clr",    32'(dmem_we),  32'd0);
        chk("rstx_addr_clr",  dmem_addr,     32'd0);
        chk("rstx_be_clr",    32'(dmem_be),  32'd0);
        chk("rstx_wdata_clr", dmem_wdata,    32'd0);
        chk("rstx_stall",     32'(stall),    32'd0);
        chk("rstx_wb_clr",    wb_if.instruction | wb_if.alu_result | wb_if.mem_data, 32'd0);
        step();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("rstx_late_ack_req",  32'(dmem_req), 32'd0);
        chk("rstx_late_ack_wb",   wb_if.mem_data | wb_if.instruction, 32'd0);
        chk("rstx_late_ack_stall", 32'(stall), 32'd0);

        repeat (3) step();
        @(negedge clk);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("wb_queue_drained",  32'(wb_q.size()),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
